// File: rtl/rv32i_types.sv
// Shared fetch-path types: decode pipeline register layout, fetch FSM states,
// reset PC and the canonical NOP encoding.
package rv32i_types;

  localparam logic [31:0] PC_RESET = 32'h1eceb000;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic [63:0] order;
  } if_id_stage_reg_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request at a time, a one-entry hold
// buffer for words returned under stall, and redirect handling on flush.
module fetch_stage
  import rv32i_types::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_signal,
  input  logic             freeze_stall,
  input  logic             flushing_inst,
  input  logic [31:0]      branch_target,
  output logic [31:0]      imem_addr,
  output logic [3:0]       imem_rmask,
  input  logic             imem_resp,
  input  logic [31:0]      imem_rdata,
  output if_id_stage_reg_t if_id,
  output logic [31:0]      imem_rdata_id
);

  fetch_state_t     state_reg, state_next;
  logic [31:0]      req_pc_reg, req_pc_next;
  logic [31:0]      next_pc_reg, next_pc_next;
  logic [31:0]      hold_word_reg, hold_word_next;
  if_id_stage_reg_t if_id_reg, if_id_next;
  logic [31:0]      rdata_id_reg, rdata_id_next;
  logic [3:0]       rmask_reg, rmask_next;

  logic        stall;
  logic [31:0] target;
  logic        deliver;
  logic [31:0] deliver_word;

  assign stall  = stall_signal | freeze_stall;
  assign target = align_pc(branch_target);

  always_comb begin
    state_next     = state_reg;
    req_pc_next    = req_pc_reg;
    next_pc_next   = next_pc_reg;
    hold_word_next = hold_word_reg;
    deliver        = 1'b0;
    deliver_word   = hold_word_reg;

    unique case (state_reg)
      IDLE: begin
        // Any response seen here belongs to a request killed by reset.
        state_next = REQ;
        if (flushing_inst) req_pc_next = target;
      end
      REQ: begin
        if (flushing_inst) begin
          if (imem_resp) begin
            req_pc_next = target;
          end else begin
            // Address must stay put until the memory answers; park the target.
            next_pc_next = target;
            state_next   = DISCARD;
          end
        end else if (imem_resp) begin
          if (stall) begin
            hold_word_next = imem_rdata;
            state_next     = HOLD;
          end else begin
            deliver      = 1'b1;
            deliver_word = imem_rdata;
            req_pc_next  = req_pc_reg + 32'd4;
          end
        end
      end
      HOLD: begin
        if (flushing_inst) begin
          req_pc_next = target;
          state_next  = REQ;
        end else if (!stall) begin
          deliver      = 1'b1;
          deliver_word = hold_word_reg;
          req_pc_next  = req_pc_reg + 32'd4;
          state_next   = REQ;
        end
      end
      DISCARD: begin
        if (flushing_inst) next_pc_next = target;
        if (imem_resp) begin
          req_pc_next = flushing_inst ? target : next_pc_reg;
          state_next  = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    if_id_next    = if_id_reg;
    rdata_id_next = rdata_id_reg;
    if (flushing_inst) begin
      if_id_next.pc    = 32'h0;
      if_id_next.valid = 1'b0;
      rdata_id_next    = NOP_INST;
    end else if (!stall) begin
      if (deliver) begin
        if_id_next.pc    = req_pc_reg;
        if_id_next.valid = 1'b1;
        if_id_next.order = if_id_reg.order + 64'd1;
        rdata_id_next    = deliver_word;
      end else begin
        if_id_next.pc    = 32'h0;
        if_id_next.valid = 1'b0;
        rdata_id_next    = NOP_INST;
      end
    end
    rmask_next = (state_next == REQ || state_next == DISCARD) ? 4'hF : 4'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      req_pc_reg    <= PC_RESET;
      next_pc_reg   <= PC_RESET;
      hold_word_reg <= NOP_INST;
      if_id_reg     <= '0;
      rdata_id_reg  <= NOP_INST;
      rmask_reg     <= 4'h0;
    end else begin
      state_reg     <= state_next;
      req_pc_reg    <= req_pc_next;
      next_pc_reg   <= next_pc_next;
      hold_word_reg <= hold_word_next;
      if_id_reg     <= if_id_next;
      rdata_id_reg  <= rdata_id_next;
      rmask_reg     <= rmask_next;
    end
  end

  assign imem_addr     = req_pc_reg;
  assign imem_rmask    = rmask_reg;
  assign if_id         = if_id_reg;
  assign imem_rdata_id = rdata_id_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a variable-latency memory model drives
// responses, and a scoreboard of expected PCs checks every delivered word.
module tb_fetch_stage;
  import rv32i_types::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall_signal;
  logic             freeze_stall;
  logic             flushing_inst;
  logic [31:0]      branch_target;
  logic [31:0]      imem_addr;
  logic [3:0]       imem_rmask;
  logic             imem_resp;
  logic [31:0]      imem_rdata;
  if_id_stage_reg_t if_id;
  logic [31:0]      imem_rdata_id;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall_signal (stall_signal),
    .freeze_stall (freeze_stall),
    .flushing_inst(flushing_inst),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_rmask   (imem_rmask),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .if_id        (if_id),
    .imem_rdata_id(imem_rdata_id)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_deliv = 0;

  // Program order the pipeline must observe: head is the next PC to deliver.
  logic [31:0] exp_q[$];

  // Memory model state
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [31:0] cap_addr = 32'h0;
  int          lat_min = 0;
  int          lat_max = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a3c96e1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus: memory response for this cycle plus control inputs.
  task automatic cycle(input logic r, input logic s, input logic fz, input logic fl,
                       input logic [31:0] tgt);
    logic reset_edge;
    @(negedge clk);
    reset_edge = rst;
    imem_resp  = 1'b0;
    if (reset_edge) begin
      busy = 1'b0;
      if (!r && $urandom_range(1) == 1) begin
        imem_resp  = 1'b1;
        imem_rdata = $urandom;
      end
    end else begin
      if (busy) begin
        check("imem_addr_stable", 64'(imem_addr), 64'(cap_addr));
        check("imem_rmask_held", 64'(imem_rmask), 64'(4'hF));
      end else if (imem_rmask == 4'hF) begin
        busy     = 1'b1;
        cap_addr = imem_addr;
        cnt      = $urandom_range(lat_max, lat_min);
        check("imem_addr_aligned", 64'(imem_addr[1:0]), 64'(2'b00));
      end
      if (busy) begin
        if (cnt == 0) begin
          imem_resp  = 1'b1;
          imem_rdata = mem_word(cap_addr);
          busy       = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
    // The cycle right after reset is IDLE; redirects are not issued there.
    if (reset_edge || rst) fl = 1'b0;
    rst           = r;
    stall_signal  = s;
    freeze_stall  = fz;
    flushing_inst = fl && !r;
    branch_target = tgt;
    if (r) begin
      exp_q.delete();
      exp_q.push_back(PC_RESET);
    end else if (fl) begin
      exp_q.delete();
      exp_q.push_back({tgt[31:2], 2'b00});
    end
  endtask

  // Monitor
  logic             m_rst, m_flush, m_stall;
  if_id_stage_reg_t prev_id;
  logic [31:0]      prev_word;
  logic [63:0]      exp_order = 64'd0;
  logic [31:0]      epc;

  initial begin
    prev_id   = '0;
    prev_word = NOP_INST;
    forever begin
      @(posedge clk);
      m_rst   = rst;
      m_flush = flushing_inst;
      m_stall = stall_signal | freeze_stall;
      #1;
      if (m_rst) begin
        exp_order = 64'd0;
        check("reset_pc", 64'(if_id.pc), 64'd0);
        check("reset_valid", 64'(if_id.valid), 64'd0);
        check("reset_order", if_id.order, 64'd0);
        check("reset_word", 64'(imem_rdata_id), 64'(NOP_INST));
        check("reset_rmask", 64'(imem_rmask), 64'd0);
        check("reset_addr", 64'(imem_addr), 64'(PC_RESET));
      end else if (m_flush) begin
        check("flush_valid", 64'(if_id.valid), 64'd0);
        check("flush_pc", 64'(if_id.pc), 64'd0);
        check("flush_word", 64'(imem_rdata_id), 64'(NOP_INST));
        check("flush_order", if_id.order, exp_order);
      end else if (m_stall) begin
        check("stall_hold_pc", 64'(if_id.pc), 64'(prev_id.pc));
        check("stall_hold_valid", 64'(if_id.valid), 64'(prev_id.valid));
        check("stall_hold_order", if_id.order, prev_id.order);
        check("stall_hold_word", 64'(imem_rdata_id), 64'(prev_word));
      end else if (if_id.valid) begin
        if (exp_q.size() == 0) begin
          check("deliver_unexpected", 64'd1, 64'd0);
        end else begin
          epc = exp_q.pop_front();
          exp_order = exp_order + 64'd1;
          n_deliv++;
          check("deliver_pc", 64'(if_id.pc), 64'(epc));
          check("deliver_word", 64'(imem_rdata_id), 64'(mem_word(epc)));
          check("deliver_order", if_id.order, exp_order);
          exp_q.push_back(epc + 32'd4);
          $display("[TB] deliver pc=%h word=%h order=%0d", if_id.pc, imem_rdata_id, if_id.order);
        end
      end else begin
        check("bubble_pc", 64'(if_id.pc), 64'd0);
        check("bubble_word", 64'(imem_rdata_id), 64'(NOP_INST));
        check("bubble_order", if_id.order, exp_order);
      end
      prev_id   = if_id;
      prev_word = imem_rdata_id;
    end
  end

  initial begin
    logic r, s, fz, fl;
    logic [31:0] tgt;
    rst = 1'b1; stall_signal = 1'b0; freeze_stall = 1'b0; flushing_inst = 1'b0;
    branch_target = 32'h0; imem_resp = 1'b0; imem_rdata = 32'h0;
    exp_q.push_back(PC_RESET);

    // Reset, then a 1-cycle memory streaming sequential words
    lat_min = 0; lat_max = 0;
    repeat (2) cycle(1, 0, 0, 0, 0);
    repeat (8) cycle(0, 0, 0, 0, 0);
    // Downstream stall for 3 cycles
    repeat (3) cycle(0, 1, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 0);
    // Redirect with an unaligned target while a slow request is outstanding
    lat_min = 3; lat_max = 3;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h1eceb103);
    repeat (10) cycle(0, 0, 0, 0, 0);
    // Memory stall into HOLD, then redirect under freeze
    lat_min = 0; lat_max = 0;
    repeat (2) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 1, 32'h00000400);
    repeat (6) cycle(0, 0, 0, 0, 0);
    // Reset while a request is outstanding
    lat_min = 2; lat_max = 2;
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    repeat (8) cycle(0, 0, 0, 0, 0);
    // PC wrap at the top of the address space
    lat_min = 0; lat_max = 1;
    cycle(0, 0, 0, 1, 32'hfffffff9);
    repeat (8) cycle(0, 0, 0, 0, 0);

    // Randomized traffic
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(199) == 0);
      s   = ($urandom_range(3) == 0);
      fz  = ($urandom_range(7) == 0);
      fl  = ($urandom_range(11) == 0);
      tgt = ($urandom_range(3) == 0) ? (32'hfffffff0 | 32'($urandom_range(15))) : $urandom;
      cycle(r, s, fz, fl, tgt);
    end
    repeat (10) cycle(0, 0, 0, 0, 0);

    check("deliveries_seen", 64'(n_deliv >= 100), 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 stall_signal  in  1  hazard stall from downstream; hold if_id.
REQ-004 freeze_stall  in  1  data-memory stall; same effect as stall_signal.
REQ-005 flushing_inst  in  1  redirect request; highest priority.
REQ-006 branch_target  in  32  redirect PC; bits [1:0] forced to 0.
REQ-007 imem_addr  out  32  instruction-memory address of the outstanding request.
REQ-008 imem_rmask  out  4  4'hF while a request is outstanding, else 4'h0.
REQ-009 imem_resp  in  1  one-cycle response strobe for the outstanding request.
REQ-010 imem_rdata  in  32  instruction word, valid only with imem_resp.
REQ-011 if_id  out  if_id_stage_reg_t  registered {pc, valid, order} to decode.
REQ-012 imem_rdata_id  out  32  registered instruction word paired with if_id.

Function
REQ-013 States: IDLE, REQ, HOLD, DISCARD; IDLE lasts exactly one cycle, then REQ.
REQ-014 In REQ and DISCARD, imem_addr = req_pc and imem_rmask = 4'hF; both stay stable until imem_resp.
REQ-015 In IDLE and HOLD, imem_rmask = 4'h0; imem_addr = req_pc.
REQ-016 Define stall = stall_signal | freeze_stall.
REQ-017 REQ, resp, !stall, !flush: next cycle, if_id = {req_pc, 1, order+1} and imem_rdata_id = imem_rdata; req_pc advances by 4; remain in REQ.
- Result: one-cycle gap from response to next address; peak throughput of one instruction per memory round trip.
REQ-018 REQ, resp, stall, !flush: latch word into hold buffer, go to HOLD; if_id and imem_rdata_id remain unchanged.
REQ-019 HOLD, !stall, !flush: transfer the held word as in REQ-017, req_pc += 4, go to REQ.
REQ-020 No instruction delivered and !stall: output a bubble.
- if_id.pc = 0, valid = 0.
- imem_rdata_id = 32'h00000013.
- order unchanged.
REQ-021 stall asserted: if_id and imem_rdata_id hold their values regardless of state.
REQ-022 Flush in any state: next cycle, if_id is a bubble per REQ-020, even when stall is asserted.
REQ-023 Flush in REQ without resp: go to DISCARD and store the target in next_pc; the outstanding address stays on imem_addr.
REQ-024 Flush in REQ with resp: drop the response; next cycle req_pc = target, state REQ.
REQ-025 Flush in HOLD: drop the held word; req_pc = target, state REQ.
REQ-026 DISCARD, resp: drop the word; req_pc = next_pc, go to REQ.
REQ-027 Flush in DISCARD: overwrite next_pc with the newest target.
REQ-028 order is a 64-bit counter that increments only when a valid instruction is delivered; it wraps modulo 2^64.
REQ-029 PC arithmetic is 32-bit and wraps modulo 2^32.

Reset
REQ-030 Reset produces the following values:
- state = IDLE; req_pc = PC_RESET (32'h1eceb000); next_pc = PC_RESET.
- if_id = {0, 0, 0}; imem_rdata_id = 32'h00000013; imem_rmask = 0.
REQ-031 Reset mid-request drops the outstanding request; any imem_resp in the following IDLE cycle is ignored.

Structure
REQ-032 rv32i_types package holds:
- if_id_stage_reg_t, extended with a 64-bit order field;
- fetch_state_t;
- PC_RESET;
- NOP_INST (32'h00000013).
REQ-033 Single module; no sub-modules.
- Next-state/PC logic is combinational.
- All outputs come from registers.

Verification
REQ-034 Reset, then memory with 1-cycle latency -> imem_addr sequence 1eceb000, 1eceb004, 1eceb008; if_id.order 1, 2, 3 with valid = 1.
REQ-035 stall_signal asserted in the cycle the resp for 1eceb004 arrives, held 3 cycles -> if_id holds the 1eceb000 instruction; rmask = 0 during hold; 1eceb004 delivered the cycle after stall drops.
REQ-036 flushing_inst with branch_target = 1eceb103 while a request is outstanding with no resp -> state DISCARD and address held; stale resp dropped; next address 1eceb100.
REQ-037 Flush and resp in the same cycle -> no instruction delivered, order unchanged, next imem_addr = target.
REQ-038 Flush while freeze_stall = 1 in HOLD -> bubble emitted (pc = 0, word 00000013); held word never appears.
REQ-039 rst asserted with a request outstanding -> next cycle rmask = 0 and outputs at reset values; a late resp is ignored; refetch starts at 1eceb000.
